// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if: ID/EXE -> EXE -> EXE/MEM bundle for the execute stage.
//   master : upstream/bench side. It drives the ID/EXE fields and flush_EXE,
//            and it observes the EXE/MEM fields and stall_EXE.
//   slave  : exe_stage side.
// Fields:
//   ID/EXE  valid, flush, ALUOp, ALUSrc, rs1/rs2/imm data, MemRead, MemWrite,
//           MemtoReg, RegWrite, rd, pc
//   EXE/MEM ALU_Result, write_data, MemRead/MemWrite, MemtoReg, RegWrite,
//           rd, pc, plus the combinational stall_EXE
// ---------------------------------------------------------------------------
interface exe_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 15;

    // ID/EXE side
    logic              valid_ID_EXE;
    logic              flush_EXE;
    logic [3:0]        ALUOp_ID_EXE;
    logic              ALUSrc_ID_EXE;
    logic [DATA_W-1:0] rs1_data_ID_EXE;
    logic [DATA_W-1:0] rs2_data_ID_EXE;
    logic [DATA_W-1:0] imm_ID_EXE;
    logic [3:0]        MemRead_ID_EXE;
    logic [3:0]        MemWrite_ID_EXE;
    logic [1:0]        MemtoReg_ID_EXE;
    logic              RegWrite_ID_EXE;
    logic [4:0]        rd_ID_EXE;
    logic [PC_W-1:0]   pc_ID_EXE;

    // EXE/MEM side
    logic [DATA_W-1:0] ALU_Result_EXE_MEM;
    logic [DATA_W-1:0] write_data_EXE_MEM;
    logic [3:0]        MemRead_EXE;
    logic [3:0]        MemWrite_EXE;
    logic [1:0]        MemtoReg_EXE_MEM;
    logic              RegWrite_EXE_MEM;
    logic [4:0]        rd_EXE_MEM;
    logic [PC_W-1:0]   pc_EXE_MEM;
    logic              stall_EXE;

    modport master (
        output valid_ID_EXE, flush_EXE, ALUOp_ID_EXE, ALUSrc_ID_EXE,
               rs1_data_ID_EXE, rs2_data_ID_EXE, imm_ID_EXE,
               MemRead_ID_EXE, MemWrite_ID_EXE, MemtoReg_ID_EXE,
               RegWrite_ID_EXE, rd_ID_EXE, pc_ID_EXE,
        input  ALU_Result_EXE_MEM, write_data_EXE_MEM, MemRead_EXE, MemWrite_EXE,
               MemtoReg_EXE_MEM, RegWrite_EXE_MEM, rd_EXE_MEM, pc_EXE_MEM, stall_EXE
    );

    modport slave (
        input  valid_ID_EXE, flush_EXE, ALUOp_ID_EXE, ALUSrc_ID_EXE,
               rs1_data_ID_EXE, rs2_data_ID_EXE, imm_ID_EXE,
               MemRead_ID_EXE, MemWrite_ID_EXE, MemtoReg_ID_EXE,
               RegWrite_ID_EXE, rd_ID_EXE, pc_ID_EXE,
        output ALU_Result_EXE_MEM, write_data_EXE_MEM, MemRead_EXE, MemWrite_EXE,
               MemtoReg_EXE_MEM, RegWrite_EXE_MEM, rd_EXE_MEM, pc_EXE_MEM, stall_EXE
    );
endinterface

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage: pipeline execute stage.
// The stage selects operand B and evaluates single-cycle ALU ops. It also runs
// a 32-iteration shift-add multiplier and a restoring divider. The EXE/MEM
// fields are registered for MEM_stage.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      exe_stage_if.slave. It carries the ID/EXE fields and flush_EXE in,
//            and the EXE/MEM fields and the combinational stall_EXE out.
// Build option:
//   EXE_DIV_EN  When it is defined, DIVU(12)/REMU(13) are multi-cycle on the
//               shared iterator. When it is not defined, the divider is absent
//               and those codes are single-cycle with result 0.
// ---------------------------------------------------------------------------
module exe_stage (
    input  logic       clk,
    input  logic       reset_n,
    exe_stage_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
`ifdef EXE_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;
`endif
    localparam logic [3:0] OP_PASSB = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              mc_hi;      // result comes from the high word (MULHU/REMU)
    logic [DATA_W-1:0] mc_b;       // latched multiplicand / divisor
    logic [DATA_W-1:0] acc_hi;     // product high / partial remainder
    logic [DATA_W-1:0] acc_lo;     // multiplier->product low / dividend->quotient
`ifdef EXE_DIV_EN
    logic              mc_div;
    logic [DATA_W:0]   div_shift_c;
    logic              div_ge_c;
    logic [DATA_W-1:0] div_rem_c;
`endif

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_c;
    logic              is_multi_c;
    logic              stall_c;
    logic [DATA_W:0]   mul_sum_c;
    logic [DATA_W-1:0] mc_result_c;
    logic              load_c;
    logic [DATA_W-1:0] res_c;

    assign op_a  = bus.rs1_data_ID_EXE;
    assign op_b  = bus.ALUSrc_ID_EXE ? bus.imm_ID_EXE : bus.rs2_data_ID_EXE;
    assign shamt = op_b[4:0];

    // Decode which opcodes use the iterative unit.
    always_comb begin
        is_multi_c = 1'b0;
        case (bus.ALUOp_ID_EXE)
            OP_MUL, OP_MULHU: is_multi_c = 1'b1;
`ifdef EXE_DIV_EN
            OP_DIVU, OP_REMU: is_multi_c = 1'b1;
`endif
            default:          is_multi_c = 1'b0;
        endcase
    end

    // Single-cycle ALU. Multi-cycle codes and code 15 fall through to 0.
    always_comb begin
        alu_c = '0;
        case (bus.ALUOp_ID_EXE)
            OP_ADD:   alu_c = op_a + op_b;
            OP_SUB:   alu_c = op_a - op_b;
            OP_AND:   alu_c = op_a & op_b;
            OP_OR:    alu_c = op_a | op_b;
            OP_XOR:   alu_c = op_a ^ op_b;
            OP_SLL:   alu_c = op_a << shamt;
            OP_SRL:   alu_c = op_a >> shamt;
            OP_SRA:   alu_c = DATA_W'($signed(op_a) >>> shamt);
            OP_SLT:   alu_c = DATA_W'($signed(op_a) < $signed(op_b));
            OP_SLTU:  alu_c = DATA_W'(op_a < op_b);
            OP_PASSB: alu_c = op_b;
            default:  alu_c = '0;
        endcase
    end

    assign stall_c = reset_n &&
                     ((state == BUSY) ||
                      ((state == IDLE) && bus.valid_ID_EXE && is_multi_c));
    assign bus.stall_EXE = stall_c;

    // Shift-add step: add the multiplicand when the multiplier LSB is 1, then
    // shift the 65-bit {carry, hi, lo} right by one.
    assign mul_sum_c = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mc_b} : {(DATA_W+1){1'b0}});

`ifdef EXE_DIV_EN
    // Restoring step. The divisor is 0 on divide-by-zero, so the compare
    // always passes. That yields an all-ones quotient and the dividend as the
    // remainder.
    assign div_shift_c = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge_c    = div_shift_c >= {1'b0, mc_b};
    assign div_rem_c   = div_ge_c ? DATA_W'(div_shift_c - {1'b0, mc_b})
                                  : div_shift_c[DATA_W-1:0];
`endif

    assign mc_result_c = mc_hi ? acc_hi : acc_lo;

    // Iterative unit control: IDLE -> BUSY (32 iterations) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            mc_hi  <= 1'b0;
            mc_b   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
`ifdef EXE_DIV_EN
            mc_div <= 1'b0;
`endif
        end else if (bus.flush_EXE) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_ID_EXE && is_multi_c) begin
                        state  <= BUSY;
                        count  <= '0;
                        mc_hi  <= bus.ALUOp_ID_EXE[0];
                        mc_b   <= op_b;
                        acc_hi <= '0;
                        acc_lo <= op_a;
`ifdef EXE_DIV_EN
                        mc_div <= bus.ALUOp_ID_EXE[2];
`endif
                    end
                end
                BUSY: begin
`ifdef EXE_DIV_EN
                    if (mc_div) begin
                        acc_hi <= div_rem_c;
                        acc_lo <= {acc_lo[DATA_W-2:0], div_ge_c};
                    end else
`endif
                    begin
                        acc_hi <= mul_sum_c[DATA_W:1];
                        acc_lo <= {mul_sum_c[0], acc_lo[DATA_W-1:1]};
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Select what the EXE/MEM register captures. Anything else is a bubble.
    always_comb begin
        load_c = 1'b0;
        res_c  = alu_c;
        if (bus.valid_ID_EXE && !bus.flush_EXE && !stall_c) begin
            if (state == DONE) begin
                load_c = 1'b1;
                res_c  = mc_result_c;
            end else if (state == IDLE) begin
                load_c = 1'b1;
            end
        end
    end

    // EXE/MEM pipeline register.
    always_ff @(posedge clk) begin
        if (!reset_n || !load_c) begin
            bus.ALU_Result_EXE_MEM <= '0;
            bus.write_data_EXE_MEM <= '0;
            bus.MemRead_EXE        <= '0;
            bus.MemWrite_EXE       <= '0;
            bus.MemtoReg_EXE_MEM   <= '0;
            bus.RegWrite_EXE_MEM   <= 1'b0;
            bus.rd_EXE_MEM         <= '0;
            bus.pc_EXE_MEM         <= '0;
        end else begin
            bus.ALU_Result_EXE_MEM <= res_c;
            bus.write_data_EXE_MEM <= bus.rs2_data_ID_EXE;
            bus.MemRead_EXE        <= bus.MemRead_ID_EXE;
            bus.MemWrite_EXE       <= bus.MemWrite_ID_EXE;
            bus.MemtoReg_EXE_MEM   <= bus.MemtoReg_ID_EXE;
            bus.RegWrite_EXE_MEM   <= bus.RegWrite_ID_EXE;
            bus.rd_EXE_MEM         <= bus.rd_ID_EXE;
            bus.pc_EXE_MEM         <= bus.pc_ID_EXE;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
`timescale 1ns/1ps
// Self-checking bench for exe_stage. The driver pushes expected EXE/MEM words
// into a queue. The monitor pops one word and compares it each time the DUT
// presents a non-bubble word.
module tb_exe_stage;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    exe_stage_if bus();
    exe_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [3:0]  mr;
        logic [3:0]  mw;
        logic [1:0]  m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [14:0] pc;
    } emem_t;

    typedef struct {
        string tag;
        emem_t data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [14:0] pc_seq   = 15'h100;

    function automatic emem_t sample_out();
        emem_t o;
        o = {bus.ALU_Result_EXE_MEM, bus.write_data_EXE_MEM, bus.MemRead_EXE,
             bus.MemWrite_EXE, bus.MemtoReg_EXE_MEM, bus.RegWrite_EXE_MEM,
             bus.rd_EXE_MEM, bus.pc_EXE_MEM};
        return o;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_bubble(input string name);
        emem_t o;
        o = sample_out();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL %s got=%h exp=0", name, o);
        end
    endtask

    task automatic idle();
        bus.valid_ID_EXE    = 1'b0;
        bus.flush_EXE       = 1'b0;
        bus.ALUOp_ID_EXE    = '0;
        bus.ALUSrc_ID_EXE   = 1'b0;
        bus.rs1_data_ID_EXE = '0;
        bus.rs2_data_ID_EXE = '0;
        bus.imm_ID_EXE      = '0;
        bus.MemRead_ID_EXE  = '0;
        bus.MemWrite_ID_EXE = '0;
        bus.MemtoReg_ID_EXE = '0;
        bus.RegWrite_ID_EXE = 1'b0;
        bus.rd_ID_EXE       = '0;
        bus.pc_ID_EXE       = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src, input logic [3:0] mr,
                         input logic [3:0] mw, input logic [1:0] m2r, input logic rw,
                         input logic [4:0] rd);
        bus.valid_ID_EXE    = 1'b1;
        bus.flush_EXE       = 1'b0;
        bus.ALUOp_ID_EXE    = op;
        bus.ALUSrc_ID_EXE   = src;
        bus.rs1_data_ID_EXE = a;
        bus.rs2_data_ID_EXE = rs2;
        bus.imm_ID_EXE      = imm;
        bus.MemRead_ID_EXE  = mr;
        bus.MemWrite_ID_EXE = mw;
        bus.MemtoReg_ID_EXE = m2r;
        bus.RegWrite_ID_EXE = rw;
        bus.rd_ID_EXE       = rd;
        bus.pc_ID_EXE       = pc_seq;
        pc_seq              = pc_seq + 15'd3;
    endtask

    // Expected word: hand-computed result plus the control fields the bench drove.
    task automatic expect_out(input string tag, input logic [31:0] alu);
        exp_t e;
        e.tag  = tag;
        e.data = {alu, bus.rs2_data_ID_EXE, bus.MemRead_ID_EXE, bus.MemWrite_ID_EXE,
                  bus.MemtoReg_ID_EXE, bus.RegWrite_ID_EXE, bus.rd_ID_EXE, bus.pc_ID_EXE};
        sb_q.push_back(e);
    endtask

    // Single-cycle op with RegWrite=1 and a nonzero rd, so the word is never a bubble.
    task automatic alu1(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic src,
                        input logic [31:0] exp);
        issue(op, a, rs2, imm, src, 4'h0, 4'h0, 2'd0, 1'b1, 5'(pc_seq[3:0]) + 5'd1);
        expect_out(tag, exp);
        @(negedge clk);
    endtask

    // Hold an op until stall drops, counting stall cycles and bubbles seen.
    task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int n_stall;
        int n_bub;
        emem_t o;
        issue(op, a, b, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'(pc_seq[3:0]) + 5'd1);
        expect_out(tag, exp);
        n_stall = 0;
        n_bub   = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            o = sample_out();
            if (i > 0 && o === '0) n_bub++;
            if (bus.stall_EXE !== 1'b1) break;
            n_stall++;
            @(negedge clk);
        end
        check_val({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        check_val({tag, "_bubbles"}, 32'(n_bub), 32'(exp_stall));
        @(negedge clk);
    endtask

    // Monitor: every non-bubble EXE/MEM word must match the head of the queue.
    initial begin
        emem_t got;
        exp_t  e;
        forever begin
            @(posedge clk);
            #1;
            got = sample_out();
            if ((|got) === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h exp=none", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e.data) begin
                        failures++;
                        $display("FAIL %s got=%h exp=%h", e.tag, got, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges with a valid ADD on the inputs.
        idle();
        reset_n = 1'b0;
        issue(4'd0, 32'd5, 32'hAAA, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'd3);
        #1;
        check_val("stall_during_reset", 32'(bus.stall_EXE), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_bubble("reset_outputs");
            check_val("reset_stall", 32'(bus.stall_EXE), 32'd0);
        end
        reset_n = 1'b1;
        expect_out("add_after_reset", 32'hAAF);
        @(negedge clk);
        check_val("add_after_reset_result", bus.ALU_Result_EXE_MEM, 32'hAAF);
        check_val("add_after_reset_rd", 32'(bus.rd_EXE_MEM), 32'd3);

        // Single-cycle operations
        alu1("sub",   4'd1,  32'd3,        32'd5,        32'h0,  1'b0, 32'hFFFFFFFE);
        alu1("sra",   4'd7,  32'h80000000, 32'h123,      32'd4,  1'b1, 32'hF8000000);
        alu1("slt",   4'd8,  32'hFFFFFFFF, 32'd1,        32'h0,  1'b0, 32'd1);
        alu1("sltu",  4'd9,  32'hFFFFFFFF, 32'd1,        32'h0,  1'b0, 32'd0);
        alu1("and",   4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,  1'b0, 32'h00F000F0);
        alu1("or",    4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,  1'b0, 32'hFFF0FFF0);
        alu1("xor",   4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,  1'b0, 32'hFF00FF00);
        alu1("sll",   4'd5,  32'd1,        32'h20,       32'd31, 1'b1, 32'h80000000);
        alu1("srl",   4'd6,  32'h80000000, 32'h24,       32'h0,  1'b0, 32'h08000000);
        alu1("passb", 4'd14, 32'h5555,     32'h77,       32'h1234, 1'b1, 32'h1234);
        alu1("op15",  4'd15, 32'h5555,     32'h77,       32'h0,  1'b0, 32'd0);
        alu1("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd2,      32'h0,  1'b0, 32'd1);

        // Store: rs2 passes to write_data with the byte enables.
        issue(4'd0, 32'h100, 32'hABCDE, 32'd8, 1'b1, 4'h0, 4'hF, 2'd0, 1'b0, 5'd0);
        expect_out("store", 32'h108);
        @(negedge clk);
        check_val("store_wdata", bus.write_data_EXE_MEM, 32'hABCDE);
        // Load control passthrough
        issue(4'd0, 32'h200, 32'h0, 32'h4, 1'b1, 4'hF, 4'h0, 2'd1, 1'b1, 5'd9);
        expect_out("load", 32'h204);
        @(negedge clk);

        // Multiplier, back to back, then a single-cycle op right after.
        run_multi("mul",   4'd10, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 33);
        run_multi("mulhu", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_multi("mul_small", 4'd10, 32'd6, 32'd7, 32'd42, 33);
        run_multi("mulhu_pow", 4'd11, 32'h80000000, 32'd4, 32'd2, 33);
        alu1("add_after_mul", 4'd0, 32'd7, 32'd8, 32'h0, 1'b0, 32'd15);

`ifdef EXE_DIV_EN
        run_multi("divu",     4'd12, 32'd100, 32'd7, 32'd14, 33);
        run_multi("remu",     4'd13, 32'd100, 32'd7, 32'd2, 33);
        run_multi("divu_by0", 4'd12, 32'd9,   32'd0, 32'hFFFFFFFF, 33);
        run_multi("remu_by0", 4'd13, 32'd9,   32'd0, 32'd9, 33);
`else
        run_multi("divu_nodiv", 4'd12, 32'd100, 32'd7, 32'd0, 0);
        run_multi("remu_nodiv", 4'd13, 32'd100, 32'd7, 32'd0, 0);
`endif

        // Flush at cycle N+10 of a MUL, then an ADD right after.
        issue(4'd10, 32'd3, 32'd5, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'd7);
        repeat (10) @(negedge clk);
        bus.flush_EXE = 1'b1;
        #1;
        check_val("flush_stall_busy", 32'(bus.stall_EXE), 32'd1);
        @(negedge clk);
        issue(4'd0, 32'd20, 32'd22, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'd8);
        expect_out("add_after_flush", 32'd42);
        #1;
        check_val("flush_stall_after", 32'(bus.stall_EXE), 32'd0);
        check_bubble("flush_bubble");
        @(negedge clk);
        check_val("add_after_flush_result", bus.ALU_Result_EXE_MEM, 32'd42);
        idle();
        repeat (40) @(negedge clk);

        // Reset in the middle of an iterative op.
`ifdef EXE_DIV_EN
        issue(4'd12, 32'd100, 32'd7, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'd11);
`else
        issue(4'd10, 32'd100, 32'd7, 32'h0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 5'd11);
`endif
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("midop_reset_stall", 32'(bus.stall_EXE), 32'd0);
        @(negedge clk);
        check_bubble("midop_reset_outputs");
        reset_n = 1'b1;
        idle();
        #1;
        check_val("post_reset_stall", 32'(bus.stall_EXE), 32'd0);
        repeat (40) @(negedge clk);
        alu1("add_post_reset", 4'd0, 32'h1000, 32'h0234, 32'h0, 1'b0, 32'h1234);
        idle();
        repeat (3) @(negedge clk);
        check_val("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
